// File: rtl/bsg_mem_nr1w_sync_fwd_pkg.sv
// Shared constants and helpers for the N-read / 1-write synchronous register file.
// The parity helper is only used when BSG_MEM_NR1W_SYNC_FWD_PARITY_EN is defined.
package bsg_mem_nr1w_sync_fwd_pkg;

    localparam int max_read_ports_gp   = 8;
    localparam int e_read_old          = 0;
    localparam int e_read_new          = 1;
    localparam int max_parity_width_gp = 1024;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [max_parity_width_gp-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bsg_mem_nr1w_sync_fwd_rport.sv
// One registered read port: array mux, range check, write-forward merge and hold.
// Parity checking of the stored word is enabled by BSG_MEM_NR1W_SYNC_FWD_PARITY_EN.
module bsg_mem_nr1w_sync_fwd_rport
    import bsg_mem_nr1w_sync_fwd_pkg::*;
#(
    parameter int width_p         = 32,
    parameter int els_p           = 64,
    parameter int fwd_p           = 1,
    parameter int addr_width_lp   = 6,
    parameter int stored_width_lp = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [stored_width_lp-1:0] mem_i [els_p],
    input  logic                       w_en_i,
    input  logic [addr_width_lp-1:0]   w_addr_i,
    input  logic [stored_width_lp-1:0] w_word_i,
    input  logic                       r_v_i,
    input  logic [addr_width_lp-1:0]   r_addr_i,
    output logic [width_p-1:0]         r_data_o,
    output logic                       r_v_o,
    output logic                       r_err_o
);

    localparam logic [addr_width_lp:0] els_lim_lp = els_p[addr_width_lp:0];

    logic [stored_width_lp-1:0] rd_word;
    logic                       in_range;
    logic                       collide;
    logic [width_p-1:0]         data_d, data_q;
    logic                       v_d, v_q;
    logic                       err_d, err_q;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < els_p; i++) begin
            if (r_addr_i == addr_width_lp'(i)) rd_word = mem_i[i];
        end
        in_range = ({1'b0, r_addr_i} < els_lim_lp);
        // w_en_i already implies an in-range write address
        collide  = w_en_i && (w_addr_i == r_addr_i);
        if ((fwd_p == e_read_new) && collide) rd_word = w_word_i;

        data_d = data_q;
        err_d  = err_q;
        v_d    = r_v_i;
        if (r_v_i) begin
            data_d = in_range ? rd_word[width_p-1:0] : '0;
`ifdef BSG_MEM_NR1W_SYNC_FWD_PARITY_EN
            err_d  = in_range &&
                     (rd_word[width_p] != even_parity(max_parity_width_gp'(rd_word[width_p-1:0])));
`else
            err_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
            v_q    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
            err_q  <= err_d;
        end
    end

    assign r_data_o = data_q;
    assign r_v_o    = v_q;
    assign r_err_o  = err_q;

endmodule

// File: rtl/bsg_mem_nr1w_sync_fwd.sv
// Synchronous-read register file: N read ports, one bit-masked write port, one clock.
// Define BSG_MEM_NR1W_SYNC_FWD_PARITY_EN to store and check one even-parity bit per entry.
module bsg_mem_nr1w_sync_fwd
    import bsg_mem_nr1w_sync_fwd_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int els_p         = 64,
    parameter int read_ports_p  = 2,
    parameter int fwd_p         = 1,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  w_v_i,
    input  logic [addr_width_lp-1:0]              w_addr_i,
    input  logic [width_p-1:0]                    w_mask_i,
    input  logic [width_p-1:0]                    w_data_i,
    input  logic [read_ports_p-1:0]               r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0] r_addr_i,
    output logic [read_ports_p*width_p-1:0]       r_data_o,
    output logic [read_ports_p-1:0]               r_v_o,
    output logic [read_ports_p-1:0]               r_err_o
);

`ifdef BSG_MEM_NR1W_SYNC_FWD_PARITY_EN
    localparam int par_bits_lp = 1;
`else
    localparam int par_bits_lp = 0;
`endif
    localparam int stored_width_lp = width_p + par_bits_lp;
    localparam logic [addr_width_lp:0] els_lim_lp = els_p[addr_width_lp:0];

    logic [stored_width_lp-1:0] mem_q [els_p];
    logic                       w_en;
    logic [width_p-1:0]         w_old_data;
    logic [width_p-1:0]         w_merged;
    logic [stored_width_lp-1:0] w_word_d;

    always_comb begin
        w_old_data = '0;
        for (int i = 0; i < els_p; i++) begin
            if (w_addr_i == addr_width_lp'(i)) w_old_data = mem_q[i][width_p-1:0];
        end
        // Writes are dropped while in reset and for addresses past the last entry
        w_en     = reset_n_i && w_v_i && ({1'b0, w_addr_i} < els_lim_lp);
        w_merged = (w_old_data & ~w_mask_i) | (w_data_i & w_mask_i);
`ifdef BSG_MEM_NR1W_SYNC_FWD_PARITY_EN
        w_word_d = {even_parity(max_parity_width_gp'(w_merged)), w_merged};
`else
        w_word_d = w_merged;
`endif
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (w_en && (w_addr_i == addr_width_lp'(i))) mem_q[i] <= w_word_d;
        end
    end

    // r_v_i[p] is a request with no back-pressure: accepted every cycle, answered next cycle.
    for (genvar p = 0; p < read_ports_p; p++) begin : g_rport
        bsg_mem_nr1w_sync_fwd_rport #(
            .width_p        (width_p),
            .els_p          (els_p),
            .fwd_p          (fwd_p),
            .addr_width_lp  (addr_width_lp),
            .stored_width_lp(stored_width_lp)
        ) u_rport (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .mem_i    (mem_q),
            .w_en_i   (w_en),
            .w_addr_i (w_addr_i),
            .w_word_i (w_word_d),
            .r_v_i    (r_v_i[p]),
            .r_addr_i (r_addr_i[p*addr_width_lp +: addr_width_lp]),
            .r_data_o (r_data_o[p*width_p +: width_p]),
            .r_v_o    (r_v_o[p]),
            .r_err_o  (r_err_o[p])
        );
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (width_p >= 1 && els_p >= 2 && read_ports_p >= 1 &&
                    read_ports_p <= max_read_ports_gp)
                else $error("bsg_mem_nr1w_sync_fwd: parameter out of range");
            if (w_v_i && !({1'b0, w_addr_i} < els_lim_lp))
                $warning("bsg_mem_nr1w_sync_fwd: write to address %0d beyond last entry dropped", w_addr_i);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_nr1w_sync_fwd.sv
// Directed bench for bsg_mem_nr1w_sync_fwd: one forwarding and one read-old instance.
module tb_bsg_mem_nr1w_sync_fwd;

  localparam int W  = 32;
  localparam int E  = 48;
  localparam int P  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          w_v = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [W-1:0]  w_mask = '0;
  logic [W-1:0]  w_data = '0;
  logic [P-1:0]  r_v = '0;
  logic [P*AW-1:0] r_addr = '0;

  logic [P*W-1:0] rd_new, rd_old;
  logic [P-1:0]   rv_new, rv_old, err_new, err_old;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_mem [E];

  always #5 clk = ~clk;

  bsg_mem_nr1w_sync_fwd #(.width_p(W), .els_p(E), .read_ports_p(P), .fwd_p(1)) u_new (
    .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .w_addr_i(w_addr), .w_mask_i(w_mask),
    .w_data_i(w_data), .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_new), .r_v_o(rv_new),
    .r_err_o(err_new));

  bsg_mem_nr1w_sync_fwd #(.width_p(W), .els_p(E), .read_ports_p(P), .fwd_p(0)) u_old (
    .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .w_addr_i(w_addr), .w_mask_i(w_mask),
    .w_data_i(w_data), .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_old), .r_v_o(rv_old),
    .r_err_o(err_old));

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] m, input logic [W-1:0] d);
    w_v = 1'b1; w_addr = a; w_mask = m; w_data = d;
    @(negedge clk);
    w_v = 1'b0;
    if (int'(a) < E) exp_mem[a] = (exp_mem[a] & ~m) | (d & m);
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    r_addr[p*AW +: AW] = a;
    r_v[p] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; r_v = '1; r_addr = '0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < P; p++) begin
      n_cmp++;
      if (rd_new[p*W +: W] !== '0 || rd_old[p*W +: W] !== '0) begin
        n_bad++;
        $display("FAIL reset_data p%0d: got %h/%h want 0", p, rd_new[p*W +: W], rd_old[p*W +: W]);
      end
    end
    n_cmp++;
    if (rv_new !== '0 || rv_old !== '0 || err_new !== '0 || err_old !== '0) begin
      n_bad++;
      $display("FAIL reset_flags: rv %b/%b err %b/%b want 0", rv_new, rv_old, err_new, err_old);
    end
    r_v = '0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_write(6'd5, '1, 32'hDEADBEEF);
    for (int p = 0; p < P; p++) set_rd(p, 6'd5);
    @(negedge clk);
    r_v = '0;
    for (int p = 0; p < P; p++) begin
      n_cmp++;
      if (rd_new[p*W +: W] !== 32'hDEADBEEF || rd_old[p*W +: W] !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL basic_data p%0d: got %h/%h want deadbeef", p, rd_new[p*W +: W], rd_old[p*W +: W]);
      end
    end
    n_cmp++;
    if (rv_new !== 4'b1111 || rv_old !== 4'b1111 || err_new !== '0 || err_old !== '0) begin
      n_bad++;
      $display("FAIL basic_valid: rv %b/%b err %b/%b want 1111/0000", rv_new, rv_old, err_new, err_old);
    end
  endtask

  task automatic test_async_reset();
    r_addr = '0; r_v = '0;
    set_rd(0, 6'd5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_new !== '0 || rd_old !== '0 || rv_new !== '0 || rv_old !== '0) begin
      n_bad++;
      $display("FAIL async_reset: data %h/%h rv %b/%b want 0", rd_new, rd_old, rv_new, rv_old);
    end
    // write attempted while in reset must be ignored
    w_v = 1'b1; w_addr = 6'd5; w_mask = '1; w_data = 32'h0;
    @(negedge clk);
    w_v = 1'b0;
    reset_n = 1'b1;
    r_v = '0; set_rd(0, 6'd5);
    @(negedge clk);
    r_v = '0;
    n_cmp++;
    if (rd_new[W-1:0] !== 32'hDEADBEEF || rd_old[W-1:0] !== 32'hDEADBEEF || rv_new !== 4'b0001) begin
      n_bad++;
      $display("FAIL after_reset_read: got %h/%h rv %b want deadbeef/0001", rd_new[W-1:0], rd_old[W-1:0], rv_new);
    end
  endtask

  task automatic test_mask();
    do_write(6'd7, '1, 32'hFFFF0000);
    do_write(6'd7, 32'h0000FFFF, 32'h12345678);
    set_rd(2, 6'd7);
    @(negedge clk);
    r_v = '0;
    n_cmp++;
    if (rd_new[2*W +: W] !== 32'hFFFF5678 || rd_old[2*W +: W] !== 32'hFFFF5678 || rv_new !== 4'b0100) begin
      n_bad++;
      $display("FAIL mask: got %h/%h rv %b want ffff5678/0100", rd_new[2*W +: W], rd_old[2*W +: W], rv_new);
    end
  endtask

  task automatic test_collision();
    do_write(6'd9, '1, 32'h1);
    set_rd(0, 6'd9); set_rd(1, 6'd9);
    do_write(6'd9, '1, 32'h2);
    r_v = '0;
    for (int p = 0; p < 2; p++) begin
      n_cmp++;
      if (rd_new[p*W +: W] !== 32'h2 || rd_old[p*W +: W] !== 32'h1) begin
        n_bad++;
        $display("FAIL collision p%0d: fwd=%h old=%h want 2/1", p, rd_new[p*W +: W], rd_old[p*W +: W]);
      end
    end
    set_rd(0, 6'd9);
    @(negedge clk);
    r_v = '0;
    n_cmp++;
    if (rd_new[W-1:0] !== 32'h2 || rd_old[W-1:0] !== 32'h2) begin
      n_bad++;
      $display("FAIL after_collision: got %h/%h want 2/2", rd_new[W-1:0], rd_old[W-1:0]);
    end
    // masked collision: forwarded value is the merged word
    set_rd(0, 6'd9);
    do_write(6'd9, 32'h000000F0, 32'h000000A5);
    r_v = '0;
    n_cmp++;
    if (rd_new[W-1:0] !== 32'hA2 || rd_old[W-1:0] !== 32'h2 || err_new !== '0) begin
      n_bad++;
      $display("FAIL masked_collision: fwd=%h old=%h err %b want a2/2/0", rd_new[W-1:0], rd_old[W-1:0], err_new);
    end
  endtask

  task automatic test_hold_range();
    for (int p = 0; p < P; p++) set_rd(p, 6'd5);
    @(negedge clk);
    r_v = '0;
    do_write(6'd5, '1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (rd_new[3*W +: W] !== 32'hDEADBEEF || rd_old[W +: W] !== 32'hDEADBEEF || rv_new !== '0) begin
        n_bad++;
        $display("FAIL hold_data c%0d: got %h/%h rv %b want deadbeef/0000", c, rd_new[3*W +: W], rd_old[W +: W], rv_new);
      end
      @(negedge clk);
    end
    // out-of-range read colliding with out-of-range write
    for (int p = 0; p < P; p++) set_rd(p, 6'd50);
    do_write(6'd50, '1, '1);
    r_v = '0;
    n_cmp++;
    if (rd_new !== '0 || rd_old !== '0 || rv_new !== 4'b1111 || rv_old !== 4'b1111) begin
      n_bad++;
      $display("FAIL range_read: data %h/%h rv %b/%b want 0/1111", rd_new, rd_old, rv_new, rv_old);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_new !== '0 || rd_old !== '0 || rv_new !== '0 || rv_old !== '0) begin
        n_bad++;
        $display("FAIL range_hold c%0d: data %h/%h rv %b/%b want 0", c, rd_new, rd_old, rv_new, rv_old);
      end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < E; i++) do_write(AW'(i), '1, {8'hC3, 8'(i), 16'(i * 37)});
    do_write(6'd50, '1, 32'hFFFFFFFF);
    do_write(6'd63, '1, 32'hFFFFFFFF);
    for (int b = 0; b < E; b += P) begin
      for (int p = 0; p < P; p++) set_rd(p, AW'(b + P - 1 - p));
      @(negedge clk);
      r_v = '0;
      for (int p = 0; p < P; p++) begin
        n_cmp++;
        if (rd_new[p*W +: W] !== exp_mem[b + P - 1 - p] || rd_old[p*W +: W] !== exp_mem[b + P - 1 - p]) begin
          n_bad++;
          $display("FAIL sweep a%0d p%0d: got %h/%h want %h", b + P - 1 - p, p,
                   rd_new[p*W +: W], rd_old[p*W +: W], exp_mem[b + P - 1 - p]);
        end
      end
    end
  endtask

  task automatic test_parity();
`ifdef BSG_MEM_NR1W_SYNC_FWD_PARITY_EN
    u_new.mem_q[3][0] = ~u_new.mem_q[3][0];
    u_old.mem_q[3][0] = ~u_old.mem_q[3][0];
    set_rd(0, 6'd3); set_rd(1, 6'd4);
    @(negedge clk);
    r_v = '0;
    n_cmp++;
    if (err_new !== 4'b0001 || err_old !== 4'b0001) begin
      n_bad++;
      $display("FAIL parity_err: got %b/%b want 0001", err_new, err_old);
    end
`else
    for (int p = 0; p < P; p++) set_rd(p, 6'd3);
    @(negedge clk);
    r_v = '0;
    n_cmp++;
    if (err_new !== '0 || err_old !== '0 || rd_new[W-1:0] !== exp_mem[3]) begin
      n_bad++;
      $display("FAIL parity_off: err %b/%b data %h want 0000/%h", err_new, err_old, rd_new[W-1:0], exp_mem[3]);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_async_reset();
    test_mask();
    test_collision();
    test_hold_range();
    test_sweep();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
